axis_port_filter: RTL and testbench

AXIS_PORT_FILTER -- requirements
Module: axis_port_filter

---
 rtl/axis_port_filter_pkg.sv | 28 ++
 rtl/axis_port_filter_if.sv | 35 +++
 rtl/axis_port_filter_port_gate.sv | 107 ++++++++++
 rtl/axis_port_filter.sv | 159 +++++++++++++++
 tb/tb_axis_port_filter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_port_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_port_filter_pkg
//  Brief    : Shared register map and per-port gate state encoding for the
//             AXIS port filter.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_port_filter_pkg;

    // Avalon byte addresses of the control/status registers
    localparam logic [7:0] c_addr_port_enable = 8'h00;
    localparam logic [7:0] c_addr_irq_enable  = 8'h01;
    localparam logic [7:0] c_addr_drop_status = 8'h02;
    localparam logic [7:0] c_addr_cnt_sel     = 8'h03;
    localparam logic [7:0] c_addr_cnt_lo      = 8'h04;
    localparam logic [7:0] c_addr_cnt_hi      = 8'h05;
    localparam logic [7:0] c_addr_cnt_clear   = 8'h06;
    localparam logic [7:0] c_addr_dest_base   = 8'h08;

    // Per-port gate state: between packets, inside a forwarded packet,
    // inside a discarded packet
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_pass = 2'd1;
    localparam state_t c_st_drop = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axis_port_filter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_port_filter_if
//  Brief    : Bundled ingress/egress AXI-Stream signals of all filter ports.
//             Port p occupies bit p / slice p of every vector.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_port_filter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int DEST_W    = 2
);
    logic [NUM_PORTS*DATA_W-1:0] ingress_tdata;
    logic [NUM_PORTS-1:0]        ingress_tvalid;
    logic [NUM_PORTS-1:0]        ingress_tlast;
    logic [NUM_PORTS-1:0]        ingress_tready;
    logic [NUM_PORTS*DATA_W-1:0] egress_tdata;
    logic [NUM_PORTS-1:0]        egress_tvalid;
    logic [NUM_PORTS-1:0]        egress_tlast;
    logic [NUM_PORTS-1:0]        egress_tready;
    logic [NUM_PORTS*DEST_W-1:0] egress_tdest;

    // Traffic source/sink side (the environment around the filter)
    modport master (
        output ingress_tdata, ingress_tvalid, ingress_tlast, egress_tready,
        input  ingress_tready, egress_tdata, egress_tvalid, egress_tlast, egress_tdest
    );

    // Filter side
    modport slave (
        input  ingress_tdata, ingress_tvalid, ingress_tlast, egress_tready,
        output ingress_tready, egress_tdata, egress_tvalid, egress_tlast, egress_tdest
    );
endinterface
`default_nettype wire

// File: rtl/axis_port_filter_port_gate.sv
`default_nettype none
// ============================================================================
//  Module   : port_gate
//  Brief    : One filter lane: packet-level pass/drop decision, tdest latch
//             and saturating pass/drop packet counters.
//  Revision : 1.0 - initial release
// ============================================================================
module port_gate
    import axis_port_filter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEST_W = 2,
    parameter int CNT_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_enable,
    input  wire logic [DEST_W-1:0] i_dest,
    input  wire logic              i_cnt_clear,
    input  wire logic [DATA_W-1:0] i_tdata,
    input  wire logic              i_tvalid,
    input  wire logic              i_tlast,
    output logic                   o_tready,
    output logic [DATA_W-1:0]      o_tdata,
    output logic                   o_tvalid,
    output logic                   o_tlast,
    output logic [DEST_W-1:0]      o_tdest,
    input  wire logic              i_tready,
    output logic [CNT_W-1:0]       o_pass_cnt,
    output logic [CNT_W-1:0]       o_drop_cnt,
    output logic                   o_drop_pulse
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DEST_W-1:0] r_dest;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              w_fwd;
    logic              w_accept;
    logic              w_pass_end;
    logic              w_drop_end;

    // Enable is only consulted between packets, so a packet is never split
    assign w_fwd      = (r_state == c_st_pass) || ((r_state == c_st_idle) && i_enable);
    assign w_accept   = i_tvalid & o_tready;
    assign w_pass_end = w_accept & i_tlast & w_fwd;
    assign w_drop_end = w_accept & i_tlast & ~w_fwd;

    // Data path is a pure wire: forwarded beats see no register stage
    assign o_tdata      = i_tdata;
    assign o_tlast      = i_tlast;
    assign o_tdest      = (r_state == c_st_idle) ? i_dest : r_dest;
    assign o_pass_cnt   = r_pass_cnt;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_drop_pulse = w_drop_end;

    // State register; reset abandons any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Next state: a multi-beat packet start picks PASS/DROP, tlast returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept && !i_tlast) w_state_nxt = i_enable ? c_st_pass : c_st_drop;
            c_st_pass,
            c_st_drop: if (w_accept && i_tlast) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Handshake outputs: forwarded lanes follow the sink, dropped lanes always accept
    always_comb begin
        o_tready = 1'b0;
        o_tvalid = 1'b0;
        if (!rst) begin
            o_tready = w_fwd ? i_tready : 1'b1;
            o_tvalid = w_fwd & i_tvalid;
        end
    end

    // Capture tdest on the first accepted beat so it holds for the whole packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_dest <= '0;
        else if (r_state == c_st_idle && w_accept) r_dest <= i_dest;
    end

    // Saturating packet counters; a clear beats a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (i_cnt_clear)                             r_pass_cnt <= '0;
            else if (w_pass_end && r_pass_cnt != c_cnt_max) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            if (i_cnt_clear)                             r_drop_cnt <= '0;
            else if (w_drop_end && r_drop_cnt != c_cnt_max) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_port_filter.sv
`default_nettype none
// ============================================================================
//  Module   : axis_port_filter
//  Brief    : NUM_PORTS-lane AXI-Stream packet filter with Avalon-MM control,
//             per-port packet counters and a drop interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_port_filter
    import axis_port_filter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int DEST_W    = 2,
    parameter int CNT_W     = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         chipselect,
    input  wire logic         write,
    input  wire logic         read,
    input  wire logic [7:0]   address,
    input  wire logic [7:0]   writedata,
    output logic [7:0]        readdata,
    output logic              irq,
    axis_port_filter_if.slave axis
);

    logic [NUM_PORTS-1:0]        r_port_enable;
    logic [NUM_PORTS-1:0]        r_irq_enable;
    logic [NUM_PORTS-1:0]        r_drop_status;
    logic [3:0]                  r_cnt_sel;
    logic [DEST_W-1:0]           r_dest [NUM_PORTS];
    logic [7:0]                  r_shadow;
    logic [7:0]                  r_readdata;
    logic                        r_irq;
    logic                        w_wr;
    logic                        w_rd;
    logic [NUM_PORTS-1:0]        w_status_clr;
    logic [NUM_PORTS-1:0]        w_cnt_clear;
    logic [NUM_PORTS-1:0]        w_drop_pulse;
    logic [CNT_W-1:0]            w_pass_cnt [NUM_PORTS];
    logic [CNT_W-1:0]            w_drop_cnt [NUM_PORTS];
    logic [15:0]                 w_cnt_val;
    logic [7:0]                  w_rd_data;
    logic [NUM_PORTS-1:0]        w_in_tready;
    logic [NUM_PORTS-1:0]        w_eg_tvalid;
    logic [NUM_PORTS-1:0]        w_eg_tlast;
    logic [NUM_PORTS*DATA_W-1:0] w_eg_tdata;
    logic [NUM_PORTS*DEST_W-1:0] w_eg_tdest;
    logic                        w_unused;

    assign w_wr         = chipselect & write;
    assign w_rd         = chipselect & read;
    assign w_status_clr = (w_wr && address == c_addr_drop_status) ? writedata[NUM_PORTS-1:0] : '0;
    assign w_cnt_clear  = (w_wr && address == c_addr_cnt_clear)   ? writedata[NUM_PORTS-1:0] : '0;
    assign w_unused     = ^writedata;
    assign readdata     = r_readdata;
    assign irq          = r_irq;

    assign axis.ingress_tready = w_in_tready;
    assign axis.egress_tvalid  = w_eg_tvalid;
    assign axis.egress_tlast   = w_eg_tlast;
    assign axis.egress_tdata   = w_eg_tdata;
    assign axis.egress_tdest   = w_eg_tdest;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_gate #(
            .DATA_W (DATA_W),
            .DEST_W (DEST_W),
            .CNT_W  (CNT_W)
        ) u_gate (
            .clk          (clk),
            .rst          (reset),
            .i_enable     (r_port_enable[p]),
            .i_dest       (r_dest[p]),
            .i_cnt_clear  (w_cnt_clear[p]),
            .i_tdata      (axis.ingress_tdata[p*DATA_W +: DATA_W]),
            .i_tvalid     (axis.ingress_tvalid[p]),
            .i_tlast      (axis.ingress_tlast[p]),
            .o_tready     (w_in_tready[p]),
            .o_tdata      (w_eg_tdata[p*DATA_W +: DATA_W]),
            .o_tvalid     (w_eg_tvalid[p]),
            .o_tlast      (w_eg_tlast[p]),
            .o_tdest      (w_eg_tdest[p*DEST_W +: DEST_W]),
            .i_tready     (axis.egress_tready[p]),
            .o_pass_cnt   (w_pass_cnt[p]),
            .o_drop_cnt   (w_drop_cnt[p]),
            .o_drop_pulse (w_drop_pulse[p])
        );
    end

    // Plain RW control registers; only bits that exist for this configuration are stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port_enable <= '0;
            r_irq_enable  <= '0;
            r_cnt_sel     <= '0;
            for (int p = 0; p < NUM_PORTS; p++) r_dest[p] <= '0;
        end else if (w_wr) begin
            case (address)
                c_addr_port_enable: r_port_enable <= writedata[NUM_PORTS-1:0];
                c_addr_irq_enable:  r_irq_enable  <= writedata[NUM_PORTS-1:0];
                c_addr_cnt_sel:     r_cnt_sel     <= writedata[3:0];
                default: ;
            endcase
            for (int p = 0; p < NUM_PORTS; p++)
                if (address == c_addr_dest_base + 8'(p)) r_dest[p] <= writedata[DEST_W-1:0];
        end
    end

    // Sticky drop flags, write-1-to-clear; a new drop in the same cycle keeps the bit set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_drop_status <= '0;
        else       r_drop_status <= (r_drop_status & ~w_status_clr) | w_drop_pulse;
    end

    // Registered interrupt level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= |(r_drop_status & r_irq_enable);
    end

    // Counter selected by cnt_sel, zero-extended to 16 bits; nonexistent ports read 0
    always_comb begin
        w_cnt_val = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (r_cnt_sel[2:0] == 3'(p))
                w_cnt_val = 16'(r_cnt_sel[3] ? w_drop_cnt[p] : w_pass_cnt[p]);
    end

    // Read data mux; unmapped and write-only addresses return 0
    always_comb begin
        w_rd_data = '0;
        case (address)
            c_addr_port_enable: w_rd_data = 8'(r_port_enable);
            c_addr_irq_enable:  w_rd_data = 8'(r_irq_enable);
            c_addr_drop_status: w_rd_data = 8'(r_drop_status);
            c_addr_cnt_sel:     w_rd_data = {4'b0000, r_cnt_sel};
            c_addr_cnt_lo:      w_rd_data = w_cnt_val[7:0];
            c_addr_cnt_hi:      w_rd_data = r_shadow;
            default: ;
        endcase
        for (int p = 0; p < NUM_PORTS; p++)
            if (address == c_addr_dest_base + 8'(p)) w_rd_data = 8'(r_dest[p]);
    end

    // Registered read port; a low-byte read freezes the high byte for a coherent 16-bit read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_shadow   <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_data;
            if (address == c_addr_cnt_lo) r_shadow <= w_cnt_val[15:8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_port_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_port_filter
//  Brief    : Self-checking bench for axis_port_filter: register table,
//             directed packet sequences and a randomized packet-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_port_filter;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 16;
    localparam int DEST_W    = 2;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       chipselect, write, read;
    logic [7:0] address, writedata;
    logic [7:0] readdata;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    axis_port_filter_if #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .DEST_W(DEST_W)) axis ();

    axis_port_filter #(
        .NUM_PORTS (NUM_PORTS),
        .DATA_W    (DATA_W),
        .DEST_W    (DEST_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .axis       (axis)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] addr;
        logic       do_wr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic read_cnt(input int port, input bit drop, output logic [15:0] v);
        logic [7:0] lo, hi;
        bus_write(8'h03, 8'(port) | (drop ? 8'h08 : 8'h00));
        bus_read(8'h04, lo);
        bus_read(8'h05, hi);
        v = {hi, lo};
    endtask

    task automatic axis_idle();
        axis.ingress_tvalid = '0;
        axis.ingress_tlast  = '0;
        axis.ingress_tdata  = '0;
        axis.egress_tready  = '1;
    endtask

    // One beat on port p, accepted on the following clock edge
    task automatic beat(input string name, input int p, input logic [DATA_W-1:0] d,
                        input logic last, input logic exp_fwd, input logic [DEST_W-1:0] exp_dest);
        axis.ingress_tvalid    = '0;
        axis.ingress_tlast     = '0;
        axis.ingress_tvalid[p] = 1'b1;
        axis.ingress_tlast[p]  = last;
        axis.ingress_tdata[p*DATA_W +: DATA_W] = d;
        #1;
        check($sformatf("%s.tready", name), 64'(axis.ingress_tready[p]), 64'(1'b1));
        check($sformatf("%s.tvalid", name), 64'(axis.egress_tvalid[p]), 64'(exp_fwd));
        if (exp_fwd) begin
            check($sformatf("%s.tdata", name), 64'(axis.egress_tdata[p*DATA_W +: DATA_W]), 64'(d));
            check($sformatf("%s.tdest", name), 64'(axis.egress_tdest[p*DEST_W +: DEST_W]), 64'(exp_dest));
            check($sformatf("%s.tlast", name), 64'(axis.egress_tlast[p]), 64'(last));
        end
        step();
        axis.ingress_tvalid = '0;
        axis.ingress_tlast  = '0;
    endtask

    // Randomized run state: packet-level view of each port
    logic [NUM_PORTS-1:0] m_en;
    logic [NUM_PORTS-1:0] m_status;
    int m_dest [NUM_PORTS];
    bit m_in_pkt [NUM_PORTS];
    bit m_pkt_fwd [NUM_PORTS];
    int m_pkt_dest [NUM_PORTS];
    int m_pass [NUM_PORTS];
    int m_drop [NUM_PORTS];

    initial begin
        reg_vec_t   regs [13];
        logic [7:0] rd;
        logic [15:0] cv;

        chipselect = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;

        // ---------------- reset state, with traffic offered during reset
        reset = 1'b1;
        axis.ingress_tvalid = '1;
        axis.ingress_tlast  = '0;
        axis.ingress_tdata  = {NUM_PORTS{16'hA5A5}};
        axis.egress_tready  = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.readdata", 64'(readdata), 64'h0);
        check("rst.irq", 64'(irq), 64'h0);
        check("rst.ingress_tready", 64'(axis.ingress_tready), 64'h0);
        check("rst.egress_tvalid", 64'(axis.egress_tvalid), 64'h0);
        axis_idle();
        reset = 1'b0;
        step();

        // ---------------- register table
        regs[0]  = '{8'h00, 1'b0, 8'h00, 8'h00};
        regs[1]  = '{8'h08, 1'b0, 8'h00, 8'h00};
        regs[2]  = '{8'h00, 1'b1, 8'hFF, 8'h0F};
        regs[3]  = '{8'h01, 1'b1, 8'h35, 8'h05};
        regs[4]  = '{8'h03, 1'b1, 8'h0B, 8'h0B};
        regs[5]  = '{8'h08, 1'b1, 8'hFF, 8'h03};
        regs[6]  = '{8'h0B, 1'b1, 8'h06, 8'h02};
        regs[7]  = '{8'h0C, 1'b1, 8'hFF, 8'h00};
        regs[8]  = '{8'h07, 1'b1, 8'hFF, 8'h00};
        regs[9]  = '{8'h06, 1'b1, 8'h00, 8'h00};
        regs[10] = '{8'h02, 1'b1, 8'h0F, 8'h00};
        regs[11] = '{8'h05, 1'b0, 8'h00, 8'h00};
        regs[12] = '{8'h04, 1'b0, 8'h00, 8'h00};
        for (int i = 0; i < 13; i++) begin
            if (regs[i].do_wr) bus_write(regs[i].addr, regs[i].wdata);
            bus_read(regs[i].addr, rd);
            check($sformatf("reg[%0d]@0x%02h", i, regs[i].addr), 64'(rd), 64'(regs[i].exp));
        end
        bus_write(8'h00, 8'h00);
        bus_write(8'h01, 8'h00);
        bus_write(8'h03, 8'h00);
        bus_write(8'h08, 8'h00);
        bus_write(8'h0B, 8'h00);

        // ---------------- three-beat forwarded packet, tdest held across a dest_reg change
        bus_write(8'h08, 8'h02);
        bus_write(8'h00, 8'h01);
        beat("p0pkt.b1", 0, 16'h1111, 1'b0, 1'b1, 2'd2);
        bus_write(8'h08, 8'h01);
        beat("p0pkt.b2", 0, 16'h2222, 1'b0, 1'b1, 2'd2);
        beat("p0pkt.b3", 0, 16'h3333, 1'b1, 1'b1, 2'd2);
        read_cnt(0, 1'b0, cv);
        check("p0.pass_cnt", 64'(cv), 64'd1);
        beat("p0single", 0, 16'h4444, 1'b1, 1'b1, 2'd1);
        read_cnt(0, 1'b0, cv);
        check("p0.pass_cnt2", 64'(cv), 64'd2);

        // ---------------- dropped packet on port 1 with interrupt
        bus_write(8'h00, 8'h00);
        bus_write(8'h01, 8'h02);
        beat("p1drop.b1", 1, 16'hBEEF, 1'b0, 1'b0, 2'd0);
        beat("p1drop.b2", 1, 16'hCAFE, 1'b1, 1'b0, 2'd0);
        read_cnt(1, 1'b1, cv);
        check("p1.drop_cnt", 64'(cv), 64'd1);
        bus_read(8'h02, rd);
        check("p1.drop_status", 64'(rd), 64'h02);
        step(); step();
        check("p1.irq_set", 64'(irq), 64'd1);
        bus_write(8'h02, 8'h02);
        step(); step();
        check("p1.irq_clr", 64'(irq), 64'd0);

        // ---------------- disable mid-packet: packet completes, next one dropped
        bus_write(8'h00, 8'h01);
        beat("p0mid.b1", 0, 16'h0101, 1'b0, 1'b1, 2'd1);
        bus_write(8'h00, 8'h00);
        beat("p0mid.b2", 0, 16'h0202, 1'b0, 1'b1, 2'd1);
        beat("p0mid.b3", 0, 16'h0303, 1'b0, 1'b1, 2'd1);
        beat("p0mid.b4", 0, 16'h0404, 1'b1, 1'b1, 2'd1);
        beat("p0next.b1", 0, 16'h0505, 1'b0, 1'b0, 2'd0);
        beat("p0next.b2", 0, 16'h0606, 1'b1, 1'b0, 2'd0);
        read_cnt(0, 1'b0, cv);
        check("p0mid.pass_cnt", 64'(cv), 64'd3);
        read_cnt(0, 1'b1, cv);
        check("p0mid.drop_cnt", 64'(cv), 64'd1);

        // ---------------- backpressure on port 2 for 5 cycles
        bus_write(8'h00, 8'h04);
        beat("p2bp.b1", 2, 16'h7001, 1'b0, 1'b1, 2'd0);
        axis.ingress_tvalid[2] = 1'b1;
        axis.ingress_tdata[2*DATA_W +: DATA_W] = 16'h7002;
        axis.egress_tready[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("p2bp.stall%0d.tready", c), 64'(axis.ingress_tready[2]), 64'd0);
            check($sformatf("p2bp.stall%0d.tvalid", c), 64'(axis.egress_tvalid[2]), 64'd1);
            check($sformatf("p2bp.stall%0d.tdata", c), 64'(axis.egress_tdata[2*DATA_W +: DATA_W]), 64'h7002);
            step();
        end
        axis.egress_tready[2] = 1'b1;
        beat("p2bp.b2", 2, 16'h7002, 1'b0, 1'b1, 2'd0);
        beat("p2bp.b3", 2, 16'h7003, 1'b1, 1'b1, 2'd0);
        read_cnt(2, 1'b0, cv);
        check("p2bp.pass_cnt", 64'(cv), 64'd1);

        // ---------------- drop flag set and W1C in the same cycle: set wins
        bus_write(8'h02, 8'h0F);
        bus_read(8'h02, rd);
        check("status.cleared", 64'(rd), 64'h00);
        axis.ingress_tvalid[3] = 1'b1;
        axis.ingress_tlast[3]  = 1'b1;
        bus_write(8'h02, 8'h08);
        axis_idle();
        bus_read(8'h02, rd);
        check("status.set_wins", 64'(rd), 64'h08);

        // ---------------- drop counter saturation on port 3
        axis.ingress_tvalid[3] = 1'b1;
        axis.ingress_tlast[3]  = 1'b1;
        repeat (CNT_MAX + 4) step();
        axis_idle();
        beat("p3sat.extra", 3, 16'h0000, 1'b1, 1'b0, 2'd0);
        bus_write(8'h03, 8'h0B);
        bus_read(8'h04, rd);
        check("p3sat.lo", 64'(rd), 64'hFF);
        bus_read(8'h05, rd);
        check("p3sat.hi", 64'(rd), 64'hFF);

        // ---------------- clear and increment in the same cycle
        axis.ingress_tvalid[3] = 1'b1;
        axis.ingress_tlast[3]  = 1'b1;
        bus_write(8'h06, 8'h08);
        axis_idle();
        read_cnt(3, 1'b1, cv);
        check("p3clr.drop_cnt", 64'(cv), 64'd0);
        read_cnt(2, 1'b0, cv);
        check("p2.untouched", 64'(cv), 64'd1);

        // ---------------- reset in the middle of a packet on port 3
        bus_write(8'h00, 8'h08);
        beat("p3rst.b1", 3, 16'h3001, 1'b0, 1'b1, 2'd0);
        axis.ingress_tvalid[3] = 1'b1;
        axis.ingress_tdata[3*DATA_W +: DATA_W] = 16'h3002;
        #1;
        reset = 1'b1;
        #1;
        check("p3rst.tvalid", 64'(axis.egress_tvalid[3]), 64'd0);
        check("p3rst.tready", 64'(axis.ingress_tready[3]), 64'd0);
        step();
        reset = 1'b0;
        beat("p3rst.after", 3, 16'h3003, 1'b1, 1'b0, 2'd0);
        read_cnt(3, 1'b1, cv);
        check("p3rst.drop_cnt", 64'(cv), 64'd1);
        read_cnt(3, 1'b0, cv);
        check("p3rst.pass_cnt", 64'(cv), 64'd0);

        // ---------------- randomized traffic against the packet model
        reset = 1'b1;
        axis_idle();
        step();
        reset = 1'b0;
        step();
        m_en = '0;
        m_status = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_dest[p] = 0; m_in_pkt[p] = 1'b0; m_pkt_fwd[p] = 1'b0;
            m_pkt_dest[p] = 0; m_pass[p] = 0; m_drop[p] = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_PORTS-1:0]        tv, tl, er, exp_tr, exp_ev, fwd;
            logic [NUM_PORTS*DATA_W-1:0] td, exp_td, act_td;
            logic [NUM_PORTS*DEST_W-1:0] exp_dd, act_dd;
            int   dexp [NUM_PORTS];
            bit   do_wr;
            logic [7:0] wa, wd;
            tv = NUM_PORTS'($urandom);
            tl = NUM_PORTS'($urandom & $urandom);
            er = NUM_PORTS'($urandom | $urandom);
            td = {$urandom, $urandom};
            do_wr = ($urandom_range(0, 9) == 0);
            wa = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(8 + $urandom_range(0, NUM_PORTS - 1));
            wd = 8'($urandom);
            axis.ingress_tvalid = tv;
            axis.ingress_tlast  = tl;
            axis.ingress_tdata  = td;
            axis.egress_tready  = er;
            chipselect = do_wr; write = do_wr; address = wa; writedata = wd;
            #1;
            exp_td = '0; act_td = '0; exp_dd = '0; act_dd = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                fwd[p]    = m_in_pkt[p] ? m_pkt_fwd[p] : m_en[p];
                dexp[p]   = m_in_pkt[p] ? m_pkt_dest[p] : m_dest[p];
                exp_tr[p] = fwd[p] ? er[p] : 1'b1;
                exp_ev[p] = fwd[p] & tv[p];
                if (exp_ev[p]) begin
                    exp_td[p*DATA_W +: DATA_W] = td[p*DATA_W +: DATA_W];
                    act_td[p*DATA_W +: DATA_W] = axis.egress_tdata[p*DATA_W +: DATA_W];
                    exp_dd[p*DEST_W +: DEST_W] = DEST_W'(dexp[p]);
                    act_dd[p*DEST_W +: DEST_W] = axis.egress_tdest[p*DEST_W +: DEST_W];
                end
            end
            check($sformatf("rand%0d.tready", i), 64'(axis.ingress_tready), 64'(exp_tr));
            check($sformatf("rand%0d.tvalid", i), 64'(axis.egress_tvalid), 64'(exp_ev));
            check($sformatf("rand%0d.tdata", i), 64'(act_td), 64'(exp_td));
            check($sformatf("rand%0d.tdest", i), 64'(act_dd), 64'(exp_dd));
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (tv[p] && exp_tr[p]) begin
                    if (!m_in_pkt[p]) begin
                        m_pkt_fwd[p]  = fwd[p];
                        m_pkt_dest[p] = dexp[p];
                    end
                    if (tl[p]) begin
                        m_in_pkt[p] = 1'b0;
                        if (fwd[p]) begin
                            if (m_pass[p] < CNT_MAX) m_pass[p]++;
                        end else begin
                            if (m_drop[p] < CNT_MAX) m_drop[p]++;
                            m_status[p] = 1'b1;
                        end
                    end else begin
                        m_in_pkt[p] = 1'b1;
                    end
                end
            end
            if (do_wr) begin
                if (wa == 8'h00) m_en = wd[NUM_PORTS-1:0];
                else             m_dest[wa - 8'h08] = int'(wd[DEST_W-1:0]);
            end
            step();
        end
        chipselect = 1'b0; write = 1'b0;
        axis_idle();
        step();
        for (int p = 0; p < NUM_PORTS; p++) begin
            read_cnt(p, 1'b0, cv);
            check($sformatf("rand.pass_cnt[%0d]", p), 64'(cv), 64'(m_pass[p]));
            read_cnt(p, 1'b1, cv);
            check($sformatf("rand.drop_cnt[%0d]", p), 64'(cv), 64'(m_drop[p]));
        end
        bus_read(8'h02, rd);
        check("rand.drop_status", 64'(rd), 64'(m_status));
        bus_write(8'h01, 8'h0F);
        step(); step();
        check("rand.irq", 64'(irq), 64'(|m_status));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
